// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: accumulates coin credit against PRICE, runs the
// dispenser req/ack handshake and returns change or refunds as Rs5 coins.
module vend_txn_ctrl #(
  parameter int PRICE   = 15,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  input  logic       cancel,
  input  logic       disp_ack,
  input  logic       chg_ack,
  output logic       out,
  output logic       disp_req,
  output logic       chg_req,
  output logic       coin_reject,
  output logic [5:0] credit,
  output logic [1:0] c_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COLLECT  = 2'b01,
    DISPENSE = 2'b10,
    CHANGE   = 2'b11
  } state_t;

  localparam logic [5:0] PRICE_V   = 6'(PRICE);
  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);
  localparam logic [5:0] CHG_COIN  = 6'd5;

  state_t     state_q, state_d;
  logic [5:0] credit_d;
  logic [7:0] cnt_q, cnt_d;
  logic       vend_d, reject_d;
  logic [5:0] coin_val;
  logic       coin_valid, coin_bad;

  always_comb begin
    coin_val   = 6'd0;
    coin_valid = 1'b0;
    coin_bad   = 1'b0;
    unique case (in)
      2'b01:   begin coin_val = 6'd5;  coin_valid = 1'b1; end
      2'b10:   begin coin_val = 6'd10; coin_valid = 1'b1; end
      2'b11:   coin_bad = 1'b1;
      default: ;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    credit_d = credit;
    cnt_d    = cnt_q;
    vend_d   = 1'b0;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        reject_d = coin_bad;
        if (coin_valid) begin
          credit_d = coin_val;
          cnt_d    = 8'd0;
          state_d  = (coin_val >= PRICE_V) ? DISPENSE : COLLECT;
        end
      end
      COLLECT: begin
        reject_d = coin_bad;
        if (coin_valid) credit_d = credit + coin_val;
        // cancel wins over a coin that would complete the price; that coin is refunded too
        if (cancel) begin
          state_d = CHANGE;
        end else if (coin_valid) begin
          cnt_d = 8'd0;
          if (credit_d >= PRICE_V) state_d = DISPENSE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d >= TIMEOUT_V) state_d = CHANGE;
        end
      end
      DISPENSE: begin
        reject_d = coin_valid | coin_bad;
        if (disp_ack) begin
          credit_d = credit - PRICE_V;
          vend_d   = 1'b1;
          state_d  = (credit_d != 6'd0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        reject_d = coin_valid | coin_bad;
        if (chg_ack) credit_d = credit - CHG_COIN;
        if (credit_d == 6'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      credit      <= 6'd0;
      cnt_q       <= 8'd0;
      out         <= 1'b0;
      disp_req    <= 1'b0;
      chg_req     <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit      <= credit_d;
      cnt_q       <= cnt_d;
      out         <= vend_d;
      disp_req    <= (state_d == DISPENSE);
      chg_req     <= (state_d == CHANGE) && (credit_d != 6'd0);
      coin_reject <= reject_d;
    end
  end

  assign c_state = state_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of credit, vending and refunding.
module tb_vend_txn_ctrl;

  localparam int PRICE   = 15;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic       cancel, disp_ack, chg_ack;
  logic       out, disp_req, chg_req, coin_reject;
  logic [5:0] credit;
  logic [1:0] c_state;

  int errors = 0;
  int checks = 0;

  // Behavioural model: money held, whether a product is being vended, whether money is going back.
  int m_credit;
  bit vending, refunding;
  int idle_cycles;
  bit exp_out, exp_rej;

  vend_txn_ctrl #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in(in), .cancel(cancel), .disp_ack(disp_ack),
    .chg_ack(chg_ack), .out(out), .disp_req(disp_req), .chg_req(chg_req),
    .coin_reject(coin_reject), .credit(credit), .c_state(c_state)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] dut_vec();
    return {c_state, credit, out, disp_req, chg_req, coin_reject};
  endfunction

  function automatic logic [11:0] model_vec();
    logic [1:0] st;
    st = refunding ? 2'd3 : vending ? 2'd2 : (m_credit > 0) ? 2'd1 : 2'd0;
    return {st, 6'(m_credit), exp_out, vending, refunding, exp_rej};
  endfunction

  task automatic model_reset();
    m_credit = 0; vending = 0; refunding = 0; idle_cycles = 0;
    exp_out = 0; exp_rej = 0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic cn, da, ca);
    int  v;
    bit  collecting;
    v = (c == 2'd1) ? 5 : (c == 2'd2) ? 10 : 0;
    exp_out = 0;
    exp_rej = 0;
    if (vending) begin
      exp_rej = (c != 2'd0);
      if (da) begin
        m_credit -= PRICE;
        exp_out   = 1;
        vending   = 0;
        refunding = (m_credit > 0);
      end
    end else if (refunding) begin
      exp_rej = (c != 2'd0);
      if (ca) begin
        m_credit -= 5;
        if (m_credit == 0) refunding = 0;
      end
    end else begin
      exp_rej    = (c == 2'd3);
      collecting = (m_credit > 0);
      if (v > 0) begin
        m_credit   += v;
        idle_cycles = 0;
      end
      if (collecting && cn) refunding = 1;
      else if (v > 0) begin
        if (m_credit >= PRICE) vending = 1;
      end else if (collecting) begin
        idle_cycles++;
        if (idle_cycles >= TIMEOUT) refunding = 1;
      end
    end
  endtask

  // Drives one cycle of inputs from a negedge, lets the posedge take them, returns at the next negedge.
  task automatic step(input logic [1:0] c, input logic cn = 0, input logic da = 0, input logic ca = 0);
    in = c; cancel = cn; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(c, cn, da, ca);
    @(negedge clk);
    in = 2'd0; cancel = 0; disp_ack = 0; chg_ack = 0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst = 1;
    for (int i = 0; i < 2; i++)
      step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
    obs = dut_vec();
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 12'h000);
    end
    rst = 0;
    step(2'd0);
    step(2'd0);
    obs = dut_vec();
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL reset_stays_idle: got %b expected %b", obs, 12'h000);
    end
  endtask

  task automatic test_exact_price();
    logic [11:0] obs, exp;
    step(2'd1);
    obs = dut_vec(); exp = {2'd1, 6'd5, 4'b0000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL exact_first_coin: got %b expected %b", obs, exp); end
    step(2'd2);
    obs = dut_vec(); exp = {2'd2, 6'd15, 4'b0100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL exact_dispense: got %b expected %b", obs, exp); end
    step(2'd0);
    step(2'd0);
    obs = dut_vec();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL exact_req_held: got %b expected %b", obs, exp); end
    step(2'd0, 0, 1);
    obs = dut_vec(); exp = {2'd0, 6'd0, 4'b1000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL exact_vend: got %b expected %b", obs, exp); end
    step(2'd0);
    obs = dut_vec(); exp = 12'h000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL exact_out_one_cycle: got %b expected %b", obs, exp); end
  endtask

  task automatic test_change_after_vend();
    logic [11:0] obs, exp;
    step(2'd2);
    step(2'd2);
    obs = dut_vec(); exp = {2'd2, 6'd20, 4'b0100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL over_dispense: got %b expected %b", obs, exp); end
    step(2'd0, 0, 1);
    obs = dut_vec(); exp = {2'd3, 6'd5, 4'b1010};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL over_change_owed: got %b expected %b", obs, exp); end
    step(2'd0, 0, 0, 1);
    obs = dut_vec(); exp = 12'h000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL over_change_done: got %b expected %b", obs, exp); end
  endtask

  task automatic test_cancel();
    logic [11:0] obs, exp;
    step(2'd2);
    step(2'd0, 1);
    obs = dut_vec(); exp = {2'd3, 6'd10, 4'b0010};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL cancel_refund: got %b expected %b", obs, exp); end
    step(2'd0, 0, 0, 1);
    obs = dut_vec(); exp = {2'd3, 6'd5, 4'b0010};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL cancel_first_coin: got %b expected %b", obs, exp); end
    step(2'd0, 0, 0, 1);
    obs = dut_vec(); exp = 12'h000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL cancel_done: got %b expected %b", obs, exp); end
    step(2'd2);
    step(2'd1, 1);
    obs = dut_vec(); exp = {2'd3, 6'd15, 4'b0010};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL cancel_beats_dispense: got %b expected %b", obs, exp); end
    for (int i = 0; i < 3; i++) step(2'd0, 0, 0, 1);
    obs = dut_vec(); exp = 12'h000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL cancel_full_refund: got %b expected %b", obs, exp); end
  endtask

  task automatic test_reject();
    logic [11:0] obs, exp;
    step(2'd3);
    obs = dut_vec(); exp = {2'd0, 6'd0, 4'b0001};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reject_invalid_idle: got %b expected %b", obs, exp); end
    step(2'd2);
    obs = dut_vec(); exp = {2'd1, 6'd10, 4'b0000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reject_pulse_cleared: got %b expected %b", obs, exp); end
    step(2'd2);
    step(2'd1);
    obs = dut_vec(); exp = {2'd2, 6'd20, 4'b0101};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reject_in_dispense: got %b expected %b", obs, exp); end
    step(2'd0, 0, 1);
    step(2'd0, 0, 1);
    obs = dut_vec(); exp = {2'd3, 6'd5, 4'b0010};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL disp_ack_in_change: got %b expected %b", obs, exp); end
    step(2'd0, 0, 0, 1);
  endtask

  task automatic test_timeout();
    logic [11:0] obs, exp;
    step(2'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) step(2'd0);
    obs = dut_vec(); exp = {2'd1, 6'd5, 4'b0000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL timeout_not_early: got %b expected %b", obs, exp); end
    step(2'd0);
    obs = dut_vec(); exp = {2'd3, 6'd5, 4'b0010};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL timeout_refund: got %b expected %b", obs, exp); end
    step(2'd0, 0, 0, 1);
    obs = dut_vec(); exp = 12'h000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL timeout_done: got %b expected %b", obs, exp); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] obs;
    step(2'd2);
    step(2'd2);
    rst = 1;
    step(2'd0);
    rst = 0;
    obs = dut_vec();
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL reset_in_dispense: got %b expected %b", obs, 12'h000); end
  endtask

  task automatic test_random();
    logic [11:0] obs, exp;
    logic [1:0]  c;
    logic        cn, da, ca;
    for (int i = 0; i < 800; i++) begin
      c  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cn = ($urandom_range(0, 11) == 0);
      da = ($urandom_range(0, 2) == 0);
      ca = ($urandom_range(0, 1) == 0);
      step(c, cn, da, ca);
      obs = dut_vec();
      exp = model_vec();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b expected %b (in=%b cancel=%b dack=%b cack=%b)",
                 i, obs, exp, c, cn, da, ca);
      end
    end
  endtask

  initial begin
    rst = 1; in = 2'd0; cancel = 0; disp_ack = 0; chg_ack = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_exact_price();
    test_change_after_vend();
    test_cancel();
    test_reject();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
